// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with majority-vote bit sampling
//
// Reassembles LSB-first bytes from an asynchronous serial line and reports
// each good byte with a one-cycle strobe. A stop bit that samples low
// discards the byte and raises a one-cycle frame error.
//
// Ports:
//   clk        system clock
//   rst        asynchronous, active-high reset
//   rx         serial line, idle high, asynchronous to clk
//   data       last correctly received byte, held until the next good byte
//   valid      one-cycle pulse: data has just been updated
//   frame_err  one-cycle pulse: stop bit sampled low, byte discarded
//   busy       high from start-edge detection until return to IDLE
module uart_rx #(
  parameter int CLKS_PER_BIT = 139
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int C  = CLKS_PER_BIT / 2;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_LO   = CW'(C - 1);
  localparam logic [CW-1:0] CNT_MID  = CW'(C);
  localparam logic [CW-1:0] CNT_DEC  = CW'(C + 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

  state_t        state;
  state_t        state_nxt;
  logic          rx_m;
  logic          rx_s;
  logic          rx_prev;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          s_lo;
  logic          s_mid;
  logic          start_edge;
  logic          at_dec;
  logic          maj;

  assign start_edge = rx_prev & ~rx_s;
  assign at_dec     = (cnt == CNT_DEC);
  // Third vote is the live sample at the decision count.
  assign maj        = (s_lo & s_mid) | (s_lo & rx_s) | (s_mid & rx_s);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    case (state)
      IDLE:    if (start_edge) state_nxt = START;
      START:   if (at_dec) state_nxt = maj ? IDLE : DATA;
      DATA:    if (at_dec && bit_idx == 3'd7) state_nxt = STOP;
      // Leaving mid stop-bit lets a back-to-back start edge be caught.
      STOP:    if (at_dec) state_nxt = maj ? IDLE : BRK;
      // A stuck-low line must go high before any new start is accepted.
      BRK:     if (rx_s) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_m      <= 1'b0;
      rx_s      <= 1'b0;
      rx_prev   <= 1'b0;
      cnt       <= '0;
      bit_idx   <= 3'd0;
      shift     <= 8'h00;
      s_lo      <= 1'b0;
      s_mid     <= 1'b0;
      data      <= 8'h00;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      // Sync flops reset low so a line held low through reset never looks
      // like a start edge until it has first been seen high.
      rx_m      <= rx;
      rx_s      <= rx_m;
      rx_prev   <= rx_s;
      valid     <= 1'b0;
      frame_err <= 1'b0;

      if (state == IDLE) begin
        cnt     <= '0;
        bit_idx <= 3'd0;
      end else begin
        cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
      end

      if (cnt == CNT_LO)  s_lo  <= rx_s;
      if (cnt == CNT_MID) s_mid <= rx_s;

      if (state == DATA && at_dec) begin
        shift[bit_idx] <= maj;
        bit_idx        <= bit_idx + 3'd1;
      end

      if (state == STOP && at_dec) begin
        if (maj) begin
          data  <= shift;
          valid <= 1'b1;
        end else begin
          frame_err <= 1'b1;
        end
      end
    end
  end

endmodule
